// File: rtl/clk_ctrl.sv
// Power/rate sequencer for the lane clock divider: reset, warm-up, run with clk40 loss detection.
// Registered outputs (req_rdy combinational); requests outside IDLE/RUN are refused, not queued.
module clk_ctrl #(
   parameter int RST_CYC  = 4,
   parameter int WARM_CYC = 16,
   parameter int LOSS_CYC = 48
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_vld,
   input  logic [1:0] pwr_req,
   output logic       req_rdy,
   input  logic       clk40,
   output logic       div_rst,
   output logic       div_enb,
   output logic [1:0] rate_sel,
   output logic       clk_ok,
   output logic [1:0] pwr_st,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DRST = 2'b01,
      WARM = 2'b10,
      RUN  = 2'b11
   } state_t;

   localparam logic [7:0] RST_LAST = 8'(RST_CYC - 1);
   localparam logic [7:0] WARM_N   = 8'(WARM_CYC);
   localparam logic [7:0] LOSS_N   = 8'(LOSS_CYC);

   state_t     state;
   logic [7:0] cnt;
   logic       edge_seen;
   logic       clk40_q;

   logic       edge_now;
   logic       acc;
   logic [7:0] cnt_inc;
   logic       seen_nxt;

   assign edge_now = clk40 & ~clk40_q;
   assign req_rdy  = (state == IDLE) || (state == RUN);
   assign acc      = req_vld & req_rdy;
   assign cnt_inc  = (cnt == 8'hff) ? cnt : cnt + 8'd1;
   assign seen_nxt = edge_seen | edge_now;
   assign pwr_st   = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         div_rst   <= 1'b1;
         div_enb   <= 1'b0;
         rate_sel  <= 2'b00;
         clk_ok    <= 1'b0;
         err       <= 1'b0;
         cnt       <= 8'd0;
         edge_seen <= 1'b0;
         clk40_q   <= 1'b0;
      end else begin
         clk40_q <= clk40;
         unique case (state)
            IDLE: begin
               if (acc) begin
                  err <= 1'b0;
                  if (pwr_req != 2'b00) begin
                     rate_sel <= pwr_req;
                     state    <= DRST;
                     cnt      <= 8'd0;
                  end
               end
            end
            DRST: begin
               if (cnt == RST_LAST) begin
                  state     <= WARM;
                  div_rst   <= 1'b0;
                  div_enb   <= 1'b1;
                  cnt       <= 8'd0;
                  edge_seen <= 1'b0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            WARM: begin
               // cnt_inc counts the current cycle, so exit happens after exactly WARM_CYC cycles
               if (cnt_inc >= WARM_N && seen_nxt) begin
                  state  <= RUN;
                  clk_ok <= 1'b1;
                  cnt    <= 8'd0;
               end else if (cnt_inc >= LOSS_N && !seen_nxt) begin
                  state    <= IDLE;
                  err      <= 1'b1;
                  div_rst  <= 1'b1;
                  div_enb  <= 1'b0;
                  clk_ok   <= 1'b0;
                  rate_sel <= 2'b00;
                  cnt      <= 8'd0;
               end else begin
                  cnt       <= cnt_inc;
                  edge_seen <= seen_nxt;
               end
            end
            RUN: begin
               // Loss is checked first so it beats a request in the same cycle
               if (!edge_now && cnt_inc >= LOSS_N) begin
                  state    <= IDLE;
                  err      <= 1'b1;
                  div_rst  <= 1'b1;
                  div_enb  <= 1'b0;
                  clk_ok   <= 1'b0;
                  rate_sel <= 2'b00;
                  cnt      <= 8'd0;
               end else begin
                  cnt <= edge_now ? 8'd0 : cnt_inc;
                  if (acc) begin
                     err <= 1'b0;
                     if (pwr_req == 2'b00) begin
                        state    <= IDLE;
                        div_rst  <= 1'b1;
                        div_enb  <= 1'b0;
                        clk_ok   <= 1'b0;
                        rate_sel <= 2'b00;
                        cnt      <= 8'd0;
                     end else if (pwr_req != rate_sel) begin
                        rate_sel  <= pwr_req;
                        state     <= WARM;
                        clk_ok    <= 1'b0;
                        cnt       <= 8'd0;
                        edge_seen <= 1'b0;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_ctrl.sv
// Directed bench for clk_ctrl: stimulus schedules expected outputs per cycle, a negedge monitor checks them.
module tb_clk_ctrl;

   logic       clk;
   logic       rst;
   logic       req_vld;
   logic [1:0] pwr_req;
   logic       req_rdy;
   logic       clk40;
   logic       div_rst;
   logic       div_enb;
   logic [1:0] rate_sel;
   logic       clk_ok;
   logic [1:0] pwr_st;
   logic       err;

   clk_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .req_vld  (req_vld),
      .pwr_req  (pwr_req),
      .req_rdy  (req_rdy),
      .clk40    (clk40),
      .div_rst  (div_rst),
      .div_enb  (div_enb),
      .rate_sel (rate_sel),
      .clk_ok   (clk_ok),
      .pwr_st   (pwr_st),
      .err      (err)
   );

   typedef struct {
      int         cyc;
      logic [8:0] mask;
      logic [8:0] val;
      string      name;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;
   logic tog    = 1'b0;
   int   t0     = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // obs bit layout: req_rdy, err, div_enb, div_rst, clk_ok, rate_sel[1:0], pwr_st[1:0]
   task automatic exp_at(input int c, input string nm, input int pst = -1, input int rate = -1,
                         input int ok = -1, input int drst = -1, input int enb = -1,
                         input int er = -1, input int rdy = -1);
      exp_t e;
      int   i;
      e.cyc  = c;
      e.name = nm;
      e.mask = '0;
      e.val  = '0;
      if (pst  >= 0) begin e.mask[1:0] = 2'b11; e.val[1:0] = 2'(pst);  end
      if (rate >= 0) begin e.mask[3:2] = 2'b11; e.val[3:2] = 2'(rate); end
      if (ok   >= 0) begin e.mask[4]   = 1'b1;  e.val[4]   = 1'(ok);   end
      if (drst >= 0) begin e.mask[5]   = 1'b1;  e.val[5]   = 1'(drst); end
      if (enb  >= 0) begin e.mask[6]   = 1'b1;  e.val[6]   = 1'(enb);  end
      if (er   >= 0) begin e.mask[7]   = 1'b1;  e.val[7]   = 1'(er);   end
      if (rdy  >= 0) begin e.mask[8]   = 1'b1;  e.val[8]   = 1'(rdy);  end
      i = 0;
      while (i < q.size() && q[i].cyc <= c) i++;
      q.insert(i, e);
   endtask

   always @(negedge clk) begin
      logic [8:0] obs;
      exp_t       e;
      obs = {req_rdy, err, div_enb, div_rst, clk_ok, rate_sel, pwr_st};
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         n_chk++;
         if ((obs & e.mask) === e.val)
            n_pass++;
         else
            $display("FAIL %s @cyc %0d: got {rdy,err,enb,drst,ok,rate,st}=%b want %b (mask %b)",
                     e.name, cyc, obs & e.mask, e.val, e.mask);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      clk40 = tog ? (((cyc - t0) / 20) % 2 != 0) : 1'b0;
   endtask

   task automatic goto(input int n);
      while (cyc < n) tick();
   endtask

   task automatic req(input logic [1:0] r);
      req_vld = 1'b1;
      pwr_req = r;
   endtask

   localparam int B = 10;

   initial begin
      rst     = 1'b1;
      req_vld = 1'b0;
      pwr_req = 2'b00;
      clk40   = 1'b0;

      exp_at(2, "reset_hold", 0, 0, 0, 1, 0, 0, 1);
      exp_at(4, "reset_idle", 0, 0, 0, 1, 0, 0, 1);
      goto(3);
      rst = 1'b0;

      // Power-up to rate10 with requests ignored in DRST and WARM
      exp_at(B+1,  "drst_entry", 1, 1, 0, 1, 0, -1, 0);
      exp_at(B+3,  "drst_ignore_req", 1, 1, -1, -1, -1, -1, 0);
      exp_at(B+4,  "drst_last", 1, -1, 0, 1, 0);
      exp_at(B+5,  "warm_entry", 2, 1, 0, 0, 1, -1, 0);
      exp_at(B+7,  "warm_ignore_req", 2, 1, 0, -1, -1, -1, 0);
      exp_at(B+20, "warm_before_ok", 2, -1, 0);
      exp_at(B+21, "run_entry", 3, 1, 1, 0, 1, 0, 1);
      goto(B);
      tog = 1'b1;
      t0  = B;
      req(2'b01);
      goto(B+1);  req_vld = 1'b0;
      goto(B+2);  req(2'b00);
      goto(B+3);  req_vld = 1'b0;
      goto(B+6);  req(2'b11);
      goto(B+7);  req_vld = 1'b0;

      // Rate change in RUN re-warms without divider reset
      exp_at(B+31, "rate_change", 2, 3, 0, 0, 1);
      exp_at(B+46, "rewarm_no_edge", 2, -1, 0);
      exp_at(B+60, "rewarm_edge_cycle", 2, -1, 0);
      exp_at(B+61, "rerun", 3, 3, 1, 0, 1);
      exp_at(B+71, "same_rate_noop", 3, 3, 1);
      goto(B+30);  req(2'b11);
      goto(B+31);  req_vld = 1'b0;
      goto(B+70);  req(2'b11);
      goto(B+71);  req_vld = 1'b0;

      // clk40 stops in RUN; a request in the loss cycle loses
      exp_at(B+148, "run_pre_loss", 3, 3, 1, -1, -1, 0);
      exp_at(B+149, "run_loss", 0, 0, 0, 1, 0, 1, 1);
      exp_at(B+155, "err_sticky", 0, -1, -1, -1, -1, 1);
      exp_at(B+156, "err_clear", 1, 2, -1, -1, -1, 0);
      goto(B+119);  tog = 1'b0;
      goto(B+148);  req(2'b10);
      goto(B+149);  req_vld = 1'b0;
      goto(B+155);  req(2'b10);
      goto(B+156);  req_vld = 1'b0;

      // Warm-up with clk40 stuck low times out
      exp_at(B+160, "warm_stuck_entry", 2, 2, 0, 0, 1);
      exp_at(B+180, "warm_stuck_mid", 2, -1, 0, -1, -1, 0);
      exp_at(B+207, "warm_stuck_last", 2, -1, 0, -1, -1, 0);
      exp_at(B+208, "warm_timeout", 0, 0, 0, 1, 0, 1, 1);

      // Fresh power-up, then power-off from RUN
      exp_at(B+216, "reup_err_clear", 1, 1, -1, -1, -1, 0);
      exp_at(B+235, "reup_warm", 2, -1, 0);
      exp_at(B+236, "reup_run", 3, 1, 1);
      exp_at(B+241, "run_off", 0, 0, 0, 1, 0, 0, 1);
      goto(B+215);
      tog = 1'b1;
      t0  = B+215;
      req(2'b01);
      goto(B+216);  req_vld = 1'b0;
      goto(B+240);  req(2'b00);
      goto(B+241);  req_vld = 1'b0;

      // Reset mid-WARM and reset overriding a request
      exp_at(B+246, "drst_r2", 1, 2);
      exp_at(B+250, "warm_r2", 2, 2, 0, 0, 1);
      exp_at(B+255, "warm_before_rst", 2);
      exp_at(B+256, "rst_mid_warm", 0, 0, 0, 1, 0, 0, 1);
      exp_at(B+261, "rst_over_req", 0, 0, 0, 1, 0, 0, 1);
      exp_at(B+262, "after_rst_req", 0, 0, 0, 1, 0);
      goto(B+245);  req(2'b10);
      goto(B+246);  req_vld = 1'b0;
      goto(B+255);  rst = 1'b1;
      goto(B+256);  rst = 1'b0;
      goto(B+260);  rst = 1'b1; req(2'b01);
      goto(B+261);  rst = 1'b0; req_vld = 1'b0;

      goto(B+270);
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         n_chk++;
         $display("FAIL pending_checks: %0d expectations never reached, want 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
